// File: rtl/debounced_pulser_pkg.sv
// Shared definitions for the debounced button pulser: one-hot channel FSM
// state encodings and helpers for sizing the per-channel counters.
package debounced_pulser_pkg;

  // One-hot channel states. Any other value is treated as illegal and
  // recovers to S_IDLE on the next clock.
  typedef enum logic [2:0] {
    S_IDLE = 3'b100,
    S_FIRE = 3'b010,
    S_HOLD = 3'b001
  } pulser_state_e;

  // Bits needed to hold a counter that counts from 0 up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Larger of two integers, used to size a counter that serves two limits.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounced_pulser_channel.sv
// One button channel: 2-flop synchroniser, stable-count debouncer, and a
// one-hot IDLE/FIRE/HOLD FSM with an optional auto-repeat counter.
module pulser_channel
  import debounced_pulser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pulse,
  output logic held
);

  // Level of the raw input when the button is not pressed.
  localparam logic RELEASED = ACTIVE_LOW;

  // Debounce counter counts the cycles a differing level has already been
  // seen; the flip happens on the cycle it would reach DEBOUNCE_CYCLES.
  localparam int                DB_MAX  = DEBOUNCE_CYCLES - 1;
  localparam int                DB_W    = cnt_width(DB_MAX);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_MAX);

  // Repeat counter starts at 0 the cycle after FIRE; a hit at value N-2
  // lands the next FIRE exactly N cycles after the previous one.
  localparam int                RPT_MAX   = max_of(REPEAT_DELAY, REPEAT_PERIOD) - 2;
  localparam int                RPT_W     = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0]  RPT_FIRST = RPT_W'(REPEAT_DELAY - 2);
  localparam logic [RPT_W-1:0]  RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 2);

  logic              sync_q1;
  logic              sync_q2;
  logic              deb_q;
  logic [DB_W-1:0]   db_cnt;
  logic              deb_pressed;

  pulser_state_e     state_q;
  pulser_state_e     state_nxt;
  logic [RPT_W-1:0]  rpt_cnt;
  logic              rpt_first;
  logic [RPT_W-1:0]  rpt_limit;
  logic              rpt_hit;

  logic              pulse_q;
  logic              held_q;

  // Two-flop synchroniser for the asynchronous button level.
  // NOTE: reset loads the released level, not 0, so an ACTIVE_LOW button
  // sitting idle does not look like a press when reset lifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= RELEASED;
      sync_q2 <= RELEASED;
    end else begin
      // NOTE: non-blocking assignments give true flop-to-flop transfer;
      // blocking here would collapse the two stages into one.
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

  // Debouncer: accept a new level only after it has been stable for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q  <= RELEASED;
      db_cnt <= '0;
    end else if (sync_q2 == deb_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      deb_q  <= sync_q2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign deb_pressed = (deb_q != RELEASED);

  // Repeat limit: first repeat after REPEAT_DELAY, later ones every REPEAT_PERIOD.
  assign rpt_limit = rpt_first ? RPT_FIRST : RPT_NEXT;
  assign rpt_hit   = REPEAT_EN && (rpt_cnt == rpt_limit);

  // Next-state logic for the channel FSM; release takes priority over repeat.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = S_IDLE;
    case (state_q)
      S_IDLE: state_nxt = deb_pressed ? S_FIRE : S_IDLE;
      S_FIRE: state_nxt = deb_pressed ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (!deb_pressed) begin
          state_nxt = S_IDLE;
        end else if (rpt_hit) begin
          state_nxt = S_FIRE;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Repeat counter: cleared outside HOLD, counts up in HOLD and saturates
  // at the active limit; tracks whether the next repeat is the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      if (state_q != S_HOLD) begin
        rpt_cnt <= '0;
      end else if (rpt_cnt != rpt_limit) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end

      if (state_q == S_IDLE) begin
        rpt_first <= 1'b1;
      end else if ((state_q == S_HOLD) && (state_nxt == S_FIRE)) begin
        rpt_first <= 1'b0;
      end
    end
  end

  // Registered outputs: pulse coincides with the FIRE state, held follows
  // the debounced level one cycle later so both rise together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      pulse_q <= (state_nxt == S_FIRE);
      held_q  <= deb_pressed;
    end
  end

  assign pulse = pulse_q;
  assign held  = held_q;

endmodule

// File: rtl/debounced_pulser.sv
// Multi-channel debounced button pulser: one independent pulser_channel
// per button bit.
module debounced_pulser
  import debounced_pulser_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] held
);

  // One channel instance per button bit; channels share only clock and reset.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulser_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .button (button[i]),
      .pulse  (pulse[i]),
      .held   (held[i])
    );
  end

endmodule

// File: tb/tb_debounced_pulser.sv
// Testbench for debounced_pulser: two instances (auto-repeat off and on)
// share the button stimulus; per-cycle expectations go through a scoreboard.
module tb_debounced_pulser;

  localparam int CH    = 4;
  localparam int N_MAX = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] button;
  logic [CH-1:0] pulse_a, held_a, pulse_r, held_r;

  always #5 clk = ~clk;

  debounced_pulser #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(64), .REPEAT_PERIOD(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .button(button), .pulse(pulse_a), .held(held_a)
  );

  debounced_pulser #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_r (
    .clk(clk), .rst_n(rst_n), .button(button), .pulse(pulse_r), .held(held_r)
  );

  typedef struct {
    int           cyc;
    logic [CH-1:0] pa;
    logic [CH-1:0] ha;
    logic [CH-1:0] pr;
    logic [CH-1:0] hr;
  } exp_t;

  exp_t          sb[$];
  logic [CH-1:0] stim [N_MAX];
  logic [CH-1:0] e_pa [N_MAX];
  logic [CH-1:0] e_ha [N_MAX];
  logic [CH-1:0] e_pr [N_MAX];
  logic [CH-1:0] e_hr [N_MAX];
  int            checks   = 0;
  int            failures = 0;
  string         test_name;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All buttons released (logic 1), nothing expected.
  task automatic clear_exp();
    for (int i = 0; i < N_MAX; i++) begin
      stim[i] = 4'hF;
      e_pa[i] = '0;
      e_ha[i] = '0;
      e_pr[i] = '0;
      e_hr[i] = '0;
    end
  endtask

  // Assert reset, confirm outputs drop at once, then release reset #1 after
  // a rising edge; that edge is cycle 0 of the next test.
  task automatic do_reset(input logic [CH-1:0] btn_during);
    rst_n = 1'b0;
    #1;
    check({test_name, " rst pulse_a"}, 32'(pulse_a), 32'h0);
    check({test_name, " rst held_a"},  32'(held_a),  32'h0);
    check({test_name, " rst pulse_r"}, 32'(pulse_r), 32'h0);
    check({test_name, " rst held_r"},  32'(held_r),  32'h0);
    button = btn_during;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive stim per cycle, push expectations, pop and compare at negedge.
  task automatic run_test(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      button = stim[c];
      e.cyc = c;
      e.pa  = e_pa[c];
      e.ha  = e_ha[c];
      e.pr  = e_pr[c];
      e.hr  = e_hr[c];
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s c%0d pulse_a", test_name, e.cyc), 32'(pulse_a), 32'(e.pa));
      check($sformatf("%s c%0d held_a",  test_name, e.cyc), 32'(held_a),  32'(e.ha));
      check($sformatf("%s c%0d pulse_r", test_name, e.cyc), 32'(pulse_r), 32'(e.pr));
      check($sformatf("%s c%0d held_r",  test_name, e.cyc), 32'(held_r),  32'(e.hr));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    button = 4'hF;
    test_name = "init";
    do_reset(4'hF);

    // Clean press on ch0 for 20 cycles: pulse at 7, held 7..26.
    // Repeat instance also fires at 17 and 22; the 27 repeat is beaten by release.
    test_name = "press";
    clear_exp();
    for (int c = 0; c < 20; c++) stim[c] = 4'b1110;
    e_pa[7] = 4'b0001;
    e_pr[7] = 4'b0001; e_pr[17] = 4'b0001; e_pr[22] = 4'b0001;
    for (int c = 7; c <= 26; c++) begin
      e_ha[c] = 4'b0001;
      e_hr[c] = 4'b0001;
    end
    run_test(32);
    do_reset(4'hF);

    // 3-cycle glitch on ch1: no pulse, held never rises.
    test_name = "glitch";
    clear_exp();
    for (int c = 0; c < 3; c++) stim[c] = 4'b1101;
    run_test(16);
    do_reset(4'hF);

    // Long hold on ch2: repeat pulses 7,17,22,...,42; none after release.
    test_name = "repeat";
    clear_exp();
    for (int c = 0; c < 40; c++) stim[c] = 4'b1011;
    e_pa[7] = 4'b0100;
    e_pr[7] = 4'b0100;
    for (int c = 17; c <= 42; c += 5) e_pr[c] = 4'b0100;
    for (int c = 7; c <= 46; c++) begin
      e_ha[c] = 4'b0100;
      e_hr[c] = 4'b0100;
    end
    run_test(52);
    do_reset(4'hF);

    // All four channels pressed together for 10 cycles.
    test_name = "all";
    clear_exp();
    for (int c = 0; c < 10; c++) stim[c] = 4'b0000;
    e_pa[7] = 4'b1111;
    e_pr[7] = 4'b1111;
    for (int c = 7; c <= 16; c++) begin
      e_ha[c] = 4'b1111;
      e_hr[c] = 4'b1111;
    end
    run_test(20);
    do_reset(4'hF);

    // Bounce 0,1,0,1 then stable low 4..13: one pulse at 11, held 11..20.
    // Repeat expiry falls in the cycle release is seen, so no pulse at 21.
    test_name = "bounce";
    clear_exp();
    stim[0] = 4'b1110; stim[1] = 4'b1111; stim[2] = 4'b1110; stim[3] = 4'b1111;
    for (int c = 4; c < 14; c++) stim[c] = 4'b1110;
    e_pa[11] = 4'b0001;
    e_pr[11] = 4'b0001;
    for (int c = 11; c <= 20; c++) begin
      e_ha[c] = 4'b0001;
      e_hr[c] = 4'b0001;
    end
    run_test(26);
    do_reset(4'hF);

    // Reset in the FIRE cycle with ch0 still pressed, then press seen as new.
    test_name = "midrst";
    clear_exp();
    for (int c = 0; c < N_MAX; c++) stim[c] = 4'b1110;
    run_test(7);
    check("midrst pre pulse_a", 32'(pulse_a), 32'h1);
    check("midrst pre held_a",  32'(held_a),  32'h1);
    do_reset(4'b1110);

    test_name = "afterrst";
    clear_exp();
    for (int c = 0; c < N_MAX; c++) stim[c] = 4'b1110;
    e_pa[7] = 4'b0001;
    e_pr[7] = 4'b0001;
    for (int c = 7; c < 14; c++) begin
      e_ha[c] = 4'b0001;
      e_hr[c] = 4'b0001;
    end
    run_test(14);
    do_reset(4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
